seg7_word_decoder: RTL and testbench

//  Inverse of the hex-to-7-segment display path. Captures a stream of 7-bit active-low

---
 rtl/seg7_pkg.sv | 33 +++
 rtl/seg7_to_hex.sv | 30 +++
 rtl/seg7_word_decoder.sv | 108 ++++++++++
 tb/tb_seg7_word_decoder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// ----------------------------------------------------------------------------
// seg7_pkg
//   Shared constants for the 7-segment decode path.
//   - SEG_CODE   : the 16 legal active-low segment codes (bit0=a .. bit6=g),
//                  indexed by the hex value they display.
//   - ST_COLLECT / ST_HOLD : state encoding for the word assembler FSM.
// ----------------------------------------------------------------------------
package seg7_pkg;

    // Active-low: a 0 bit means the segment is lit.
    localparam logic [15:0][6:0] SEG_CODE = {
        7'b0001110,   // F
        7'b0000110,   // E
        7'b0100001,   // d
        7'b1000110,   // C
        7'b0000011,   // b
        7'b0001000,   // A
        7'b0011000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_HOLD    = 1'b1;

endpackage

// File: rtl/seg7_to_hex.sv
// ----------------------------------------------------------------------------
// seg7_to_hex
//   Combinational inverse of a hex-to-7-segment encoder.
//   Ports:
//     iSEG     in  7  active-low segment code, bit0=a .. bit6=g
//     oNibble  out 4  decoded hex value (4'h0 when the code is illegal)
//     oLegal   out 1  1 when iSEG matches one of the 16 legal codes
// ----------------------------------------------------------------------------
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] iSEG,
    output logic [3:0] oNibble,
    output logic       oLegal
);

    // NOTE: every output gets a default before the search loop so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        oNibble = 4'h0;
        oLegal  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (iSEG == SEG_CODE[i]) begin
                oNibble = 4'(i);
                oLegal  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_word_decoder.sv
// ----------------------------------------------------------------------------
// seg7_word_decoder
//   Captures a stream of active-low 7-segment codes (most significant digit
//   first), decodes each to a nibble and assembles a DIGITS*4-bit word that
//   is offered on a valid/ready hold interface.
//   Ports:
//     Clock       in   1        rising-edge clock
//     Resetn      in   1        synchronous active-low reset
//     iSEG        in   7        segment code, 0 = segment lit
//     iValid      in   1        iSEG valid this cycle
//     oReady      out  1        code accepted when iValid && oReady
//     oWord       out  4*DIGITS assembled word, first digit in MSBs
//     oWordValid  out  1        oWord complete and stable
//     iWordReady  in   1        word taken when oWordValid && iWordReady
//     oErr        out  1        an illegal code appeared in this word
//     oDigitCnt   out  CNT_W    digits accepted into the current word
// ----------------------------------------------------------------------------
module seg7_word_decoder
    import seg7_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                         Clock,
    input  logic                         Resetn,
    input  logic [6:0]                   iSEG,
    input  logic                         iValid,
    output logic                         oReady,
    output logic [4*DIGITS-1:0]          oWord,
    output logic                         oWordValid,
    input  logic                         iWordReady,
    output logic                         oErr,
    output logic [$clog2(DIGITS+1)-1:0]  oDigitCnt
);

    localparam int W     = 4 * DIGITS;
    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DIGITS - 1);

    logic [0:0]       state_q, state_d;
    logic [W-1:0]     word_q,  word_d;
    logic             err_q,   err_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic [3:0]       nibble;
    logic             legal;
    logic             accept;

    seg7_to_hex u_seg7_to_hex (
        .iSEG    (iSEG),
        .oNibble (nibble),
        .oLegal  (legal)
    );

    // Codes are only taken while collecting; in HOLD iValid is ignored.
    assign accept = iValid && (state_q == ST_COLLECT);

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_COLLECT: begin
                if (accept) begin
                    word_d = {word_q[W-5:0], nibble};
                    err_d  = err_q | ~legal;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // The word itself is left in place; the next word
                // overwrites it by shifting.
                if (iWordReady) begin
                    state_d = ST_COLLECT;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= ST_COLLECT;
            word_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign oReady     = (state_q == ST_COLLECT);
    assign oWordValid = (state_q == ST_HOLD);
    assign oWord      = word_q;
    assign oErr       = err_q;
    assign oDigitCnt  = cnt_q;

endmodule

// File: tb/tb_seg7_word_decoder.sv
module tb_seg7_word_decoder;

    localparam int DIGITS = 4;

    // Forward hex -> active-low segment encoder (g..a), independent of the DUT.
    localparam logic [6:0] FWD [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic [6:0]  iSEG = '0;
    logic        iValid = 1'b0;
    logic        iWordReady = 1'b0;
    logic        oReady;
    logic [15:0] oWord;
    logic        oWordValid;
    logic        oErr;
    logic [2:0]  oDigitCnt;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: the last DIGITS accepted nibbles (oldest first),
    // the number of digits in the current word and its sticky error.
    int m_hist[$];
    int m_cnt;
    bit m_err;

    seg7_word_decoder #(.DIGITS(DIGITS)) dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .iSEG       (iSEG),
        .iValid     (iValid),
        .oReady     (oReady),
        .oWord      (oWord),
        .oWordValid (oWordValid),
        .iWordReady (iWordReady),
        .oErr       (oErr),
        .oDigitCnt  (oDigitCnt)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void ref_decode(input logic [6:0] s, output int nib, output bit ok);
        nib = 0;
        ok  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (FWD[i] == s) begin
                nib = i;
                ok  = 1'b1;
            end
        end
    endfunction

    function automatic logic [15:0] m_word();
        int w = 0;
        foreach (m_hist[i]) w = w * 16 + m_hist[i];
        return 16'(w);
    endfunction

    task automatic model_reset();
        m_hist = '{0, 0, 0, 0};
        m_cnt  = 0;
        m_err  = 1'b0;
    endtask

    // Apply one cycle of inputs, advance the model, compare all outputs.
    task automatic step(input bit v, input logic [6:0] s, input bit wr, input bit rn);
        int  nib;
        bit  ok;
        iValid     = v;
        iSEG       = s;
        iWordReady = wr;
        Resetn     = rn;
        @(posedge Clock);
        if (!rn) begin
            model_reset();
        end else if (m_cnt == DIGITS) begin
            if (wr) begin
                m_cnt = 0;
                m_err = 1'b0;
            end
        end else if (v) begin
            ref_decode(s, nib, ok);
            m_hist.push_back(nib);
            void'(m_hist.pop_front());
            m_err = m_err | !ok;
            m_cnt++;
        end
        #1;
        check("ready",     16'(oReady),     16'(m_cnt != DIGITS));
        check("wordvalid", 16'(oWordValid), 16'(m_cnt == DIGITS));
        check("word",      oWord,           m_word());
        check("err",       16'(oErr),       16'(m_err));
        check("digitcnt",  16'(oDigitCnt),  16'(m_cnt));
    endtask

    task automatic send(input logic [6:0] s);
        step(1'b1, s, 1'b0, 1'b1);
    endtask

    task automatic release_word();
        step(1'b0, 7'h00, 1'b1, 1'b1);
    endtask

    function automatic logic [6:0] rand_seg();
        if ($urandom_range(0, 9) == 0) return 7'($urandom);
        return FWD[$urandom_range(0, 15)];
    endfunction

    initial begin
        model_reset();

        // Reset state.
        step(1'b0, 7'h00, 1'b0, 1'b0);
        step(1'b0, 7'h00, 1'b0, 1'b0);

        // 1: digits 1,2,3,4 back to back; valid after the 4th accept.
        send(FWD[1]); send(FWD[2]); send(FWD[3]);
        check("t1_valid_early", 16'(oWordValid), 16'd0);
        send(FWD[4]);
        check("t1_word",  oWord,            16'h1234);
        check("t1_valid", 16'(oWordValid),  16'd1);
        check("t1_err",   16'(oErr),        16'd0);
        check("t1_cnt",   16'(oDigitCnt),   16'd4);
        release_word();

        // 2: round-trip all 16 nibbles as four words.
        for (int w = 0; w < 4; w++) begin
            for (int d = 0; d < 4; d++) send(FWD[w * 4 + d]);
            check("t2_word", oWord, 16'((4 * w) * 4096 + (4 * w + 1) * 256 + (4 * w + 2) * 16 + (4 * w + 3)));
            check("t2_err",  16'(oErr), 16'd0);
            release_word();
        end

        // 3: illegal code in the third position, then a clean word.
        send(FWD[10]); send(FWD[11]); send(7'h7F); send(FWD[15]);
        check("t3_word", oWord,     16'hAB0F);
        check("t3_err",  16'(oErr), 16'd1);
        release_word();
        check("t3_err_clr", 16'(oErr), 16'd0);
        for (int d = 0; d < 4; d++) send(FWD[8]);
        check("t3_word2", oWord,     16'h8888);
        check("t3_err2",  16'(oErr), 16'd0);
        release_word();

        // 4: held word ignores iValid; code coinciding with iWordReady drops.
        send(FWD[5]); send(FWD[6]); send(FWD[7]); send(FWD[9]);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, FWD[$urandom_range(0, 15)], 1'b0, 1'b1);
            check("t4_hold_word",  oWord,         16'h5679);
            check("t4_hold_ready", 16'(oReady),   16'd0);
        end
        step(1'b1, FWD[3], 1'b1, 1'b1);
        check("t4_dropped_cnt", 16'(oDigitCnt), 16'd0);
        send(FWD[12]);
        check("t4_next_cnt", 16'(oDigitCnt), 16'd1);
        send(FWD[13]); send(FWD[14]); send(FWD[1]);
        check("t4_next_word", oWord, 16'hCDE1);
        release_word();

        // 5: reset mid-word and in HOLD, then a clean word.
        send(FWD[2]); send(FWD[3]);
        step(1'b1, FWD[4], 1'b0, 1'b0);
        check("t5_rst_word", oWord,          16'h0000);
        check("t5_rst_cnt",  16'(oDigitCnt), 16'd0);
        send(FWD[1]); send(7'h55); send(FWD[2]); send(FWD[3]);
        step(1'b1, FWD[4], 1'b1, 1'b0);
        check("t5_rst_hold_valid", 16'(oWordValid), 16'd0);
        check("t5_rst_hold_err",   16'(oErr),       16'd0);
        send(FWD[9]); send(FWD[12]); send(FWD[13]); send(FWD[14]);
        check("t5_word", oWord, 16'h9CDE);
        release_word();

        // 6: random gaps, random codes (some illegal), random consumer stalls.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 2) == 0), rand_seg(), ($urandom_range(0, 3) == 0), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
